// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, multiplier FSM states
// and operand forwarding selects.
package exec_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one partial-product bit per cycle,
// XLEN cycles after start. The product register holds its value until restarted.
module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              running;
    logic [XLEN:0]     sum;

    // Upper half accumulates the multiplicand; the lower half starts as the
    // multiplier and is consumed LSB first as the whole register shifts right.
    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    end

    assign done    = running && (cnt == LAST);
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, b};
            mcand   <= a;
        end else if (running) begin
            acc <= {sum, acc[XLEN-1:1]};
            cnt <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage_md.sv
// Execute stage with two-level forwarding, ALU, iterative MUL/MULHU and the
// EX/MEM pipeline register.
module exec_stage_md
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_data1,
    input  logic [XLEN-1:0] id_data2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_wb,
    input  logic [1:0]      id_mem,
    input  logic [3:0]      id_aluop,
    input  logic            id_alusrc,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    output logic            ex_busy,
    output logic            ex_valid,
    output logic            ex_wb,
    output logic [1:0]      ex_mem,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_wdata,
    output logic [4:0]      ex_rd
);

    localparam int SHW = $clog2(XLEN);

    state_e            state;
    state_e            next_state;
    fwd_sel_e          sel1;
    fwd_sel_e          sel2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              is_mul;
    logic              issue;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_product;
    logic [XLEN-1:0]   mul_res;
    logic              mul_hi;
    logic              mul_wb;
    logic [4:0]        mul_rd;

    // The instruction in EX/MEM is younger than the one in WB, so it wins.
    always_comb begin
        sel1 = FWD_RF;
        sel2 = FWD_RF;
        if (ex_valid && ex_wb && (ex_rd != 5'd0) && (ex_rd == id_rs1)) begin
            sel1 = FWD_EX;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1)) begin
            sel1 = FWD_WB;
        end
        if (ex_valid && ex_wb && (ex_rd != 5'd0) && (ex_rd == id_rs2)) begin
            sel2 = FWD_EX;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2)) begin
            sel2 = FWD_WB;
        end
    end

    always_comb begin
        case (sel1)
            FWD_EX:  rs1_val = ex_result;
            FWD_WB:  rs1_val = wb_data;
            default: rs1_val = id_data1;
        endcase
        case (sel2)
            FWD_EX:  rs2_val = ex_result;
            FWD_WB:  rs2_val = wb_data;
            default: rs2_val = id_data2;
        endcase
        opa = rs1_val;
        opb = id_alusrc ? id_imm : rs2_val;
    end

    always_comb begin
        alu_res = '0;
        shamt   = opb[SHW-1:0];
        case (id_aluop)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            default: alu_res = '0;
        endcase
    end

    assign is_mul = MUL_EN && is_mul_op(id_aluop);
    assign issue  = (state == ST_IDLE) && id_valid && is_mul && !flush && !mem_stall;

    seq_multiplier #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (issue),
        .abort   (flush),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_res = mul_hi ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE drops busy so ID/EX may advance at the same edge the product lands.
    always_comb begin
        next_state = state;
        ex_busy    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    next_state = ST_RUN;
                    ex_busy    = 1'b1;
                end
            end
            ST_RUN: begin
                ex_busy = 1'b1;
                if (mul_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!mem_stall) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_hi <= 1'b0;
            mul_wb <= 1'b0;
            mul_rd <= 5'd0;
        end else if (issue) begin
            mul_hi <= (id_aluop == OP_MULHU);
            mul_wb <= id_wb;
            mul_rd <= id_rd;
        end
    end

    // Bubbles clear only the control fields; data fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_wb     <= 1'b0;
            ex_mem    <= 2'b00;
            ex_result <= '0;
            ex_wdata  <= '0;
            ex_rd     <= 5'd0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_wb    <= 1'b0;
            ex_mem   <= 2'b00;
        end else if (!mem_stall) begin
            if (state == ST_DONE) begin
                ex_valid  <= 1'b1;
                ex_wb     <= mul_wb;
                ex_mem    <= 2'b00;
                ex_result <= mul_res;
                ex_rd     <= mul_rd;
            end else if ((state == ST_RUN) || issue || !id_valid) begin
                ex_valid <= 1'b0;
                ex_wb    <= 1'b0;
                ex_mem   <= 2'b00;
            end else begin
                ex_valid  <= 1'b1;
                ex_wb     <= id_wb;
                ex_mem    <= id_mem;
                ex_result <= alu_res;
                ex_wdata  <= rs2_val;
                ex_rd     <= id_rd;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_md.sv
// Directed bench for exec_stage_md: forwarding, ALU ops, multiplier timing,
// mem_stall hold, flush and reset.
module tb_exec_stage_md;
    import exec_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            mem_stall;
    logic            flush;
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_data1;
    logic [XLEN-1:0] id_data2;
    logic [XLEN-1:0] id_imm;
    logic            id_wb;
    logic [1:0]      id_mem;
    logic [3:0]      id_aluop;
    logic            id_alusrc;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic            ex_busy;
    logic            ex_valid;
    logic            ex_wb;
    logic [1:0]      ex_mem;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_wdata;
    logic [4:0]      ex_rd;

    int total = 0;
    int bad   = 0;

    exec_stage_md #(
        .XLEN   (XLEN),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_stall (mem_stall),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_data1  (id_data1),
        .id_data2  (id_data2),
        .id_imm    (id_imm),
        .id_wb     (id_wb),
        .id_mem    (id_mem),
        .id_aluop  (id_aluop),
        .id_alusrc (id_alusrc),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .ex_busy   (ex_busy),
        .ex_valid  (ex_valid),
        .ex_wb     (ex_wb),
        .ex_mem    (ex_mem),
        .ex_result (ex_result),
        .ex_wdata  (ex_wdata),
        .ex_rd     (ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkExMem(input string tag, input logic valid, input logic wb,
                              input logic [1:0] mem, input logic [4:0] rd,
                              input logic [31:0] result);
        checkOutput(tag, {23'd0, ex_valid, ex_wb, ex_mem, ex_rd, ex_result},
                         {23'd0, valid, wb, mem, rd, result});
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] op,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm,
                                 input logic alusrc, input logic wb,
                                 input logic [1:0] mem);
        id_valid  = valid;
        id_aluop  = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_data1  = d1;
        id_data2  = d2;
        id_imm    = imm;
        id_alusrc = alusrc;
        id_wb     = wb;
        id_mem    = mem;
    endtask

    task automatic setWriteback(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we   = we;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic aluCase(input string tag, input logic [3:0] op, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] imm,
                           input logic alusrc, input logic [4:0] rd,
                           input logic [31:0] expected);
        applyStimulus(1'b1, op, 5'd12, 5'd13, rd, d1, d2, imm, alusrc, 1'b1, 2'b00);
        tick();
        checkExMem(tag, 1'b1, 1'b1, 2'b00, rd, expected);
    endtask

    // Issue at T, expect busy through T+XLEN, DONE at T+XLEN+1 (held while
    // stalled), result one edge after DONE is allowed to advance.
    task automatic doMul(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int stall_cycles, input logic [31:0] expected);
        int busy_count;
        int valid_count;
        int stall_bad;
        applyStimulus(1'b1, op, 5'd16, 5'd17, rd, a, b, 32'd0, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        checkOutput({tag, "_busy_issue"}, 64'(ex_busy), 64'd1);
        busy_count  = 0;
        valid_count = 0;
        for (int i = 1; i <= XLEN; i++) begin
            tick();
            @(negedge clk);
            if (ex_busy) busy_count++;
            if (ex_valid) valid_count++;
        end
        checkOutput({tag, "_busy_cycles"}, 64'(busy_count), 64'(XLEN));
        checkOutput({tag, "_run_bubbles"}, 64'(valid_count), 64'd0);
        tick();
        mem_stall = (stall_cycles > 0);
        stall_bad = 0;
        for (int s = 0; s < stall_cycles; s++) begin
            @(negedge clk);
            if (ex_busy !== 1'b0 || ex_valid !== 1'b0 || dut.state !== ST_DONE) stall_bad++;
            tick();
            if (s == stall_cycles - 1) mem_stall = 1'b0;
        end
        if (stall_cycles > 0) begin
            checkOutput({tag, "_stall_hold_done"}, 64'(stall_bad), 64'd0);
        end
        @(negedge clk);
        checkOutput({tag, "_done_busy"}, 64'(ex_busy), 64'd0);
        checkOutput({tag, "_done_state"}, 64'(dut.state), 64'(ST_DONE));
        tick();
        bubble();
        checkExMem({tag, "_result"}, 1'b1, 1'b1, 2'b00, rd, expected);
    endtask

    initial begin
        int late_valid;

        rst       = 1'b1;
        mem_stall = 1'b0;
        flush     = 1'b0;
        bubble();
        setWriteback(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        checkExMem("reset_exmem", 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
        checkOutput("reset_wdata", 64'(ex_wdata), 64'd0);
        @(negedge clk);
        checkOutput("reset_busy", 64'(ex_busy), 64'd0);
        rst = 1'b0;

        // Forwarding priority and store data
        applyStimulus(1'b1, OP_ADD, 5'd10, 5'd11, 5'd1, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 2'b00);
        tick();
        checkExMem("add_basic", 1'b1, 1'b1, 2'b00, 5'd1, 32'd12);
        setWriteback(1'b1, 5'd1, 32'd99);
        applyStimulus(1'b1, OP_ADD, 5'd1, 5'd1, 5'd2, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 2'b00);
        tick();
        checkExMem("fwd_ex_over_wb", 1'b1, 1'b1, 2'b00, 5'd2, 32'd24);
        setWriteback(1'b1, 5'd3, 32'hDEADBEEF);
        applyStimulus(1'b1, OP_ADD, 5'd4, 5'd3, 5'd0, 32'h1000, 32'h11, 32'd8, 1'b1, 1'b0, 2'b01);
        tick();
        checkExMem("store_addr", 1'b1, 1'b0, 2'b01, 5'd0, 32'h1008);
        checkOutput("store_wdata_fwd_wb", 64'(ex_wdata), 64'hDEADBEEF);
        setWriteback(1'b1, 5'd0, 32'hFF);
        applyStimulus(1'b1, OP_OR, 5'd0, 5'd6, 5'd5, 32'd0, 32'h30, 32'd0, 1'b0, 1'b1, 2'b00);
        tick();
        checkExMem("x0_no_fwd", 1'b1, 1'b1, 2'b00, 5'd5, 32'h30);
        setWriteback(1'b0, 5'd0, 32'd0);

        // ALU ops, shift-amount masking and compare boundaries
        aluCase("sra_amt33",  OP_SRA,  32'h80000000, 32'd0, 32'd33, 1'b1, 5'd20, 32'hC0000000);
        aluCase("slt_neg",    OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd21, 32'd1);
        aluCase("sltu_max",   OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd22, 32'd0);
        aluCase("sub_wrap",   OP_SUB,  32'd3, 32'd5, 32'd0, 1'b0, 5'd23, 32'hFFFFFFFE);
        aluCase("sll_amt33",  OP_SLL,  32'd1, 32'd0, 32'h21, 1'b1, 5'd24, 32'd2);
        aluCase("srl_amt63",  OP_SRL,  32'h80000000, 32'd0, 32'h3F, 1'b1, 5'd25, 32'd1);
        aluCase("xor",        OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd26, 32'h0FF00FF0);
        aluCase("and",        OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd27, 32'hF000F000);
        aluCase("op13_zero",  4'd13,   32'd5, 32'd6, 32'd0, 1'b0, 5'd28, 32'd0);
        aluCase("add_wrap",   OP_ADD,  32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 5'd29, 32'd1);
        bubble();
        tick();
        checkOutput("bubble_ctrl", 64'({ex_valid, ex_wb, ex_mem}), 64'd0);

        // mem_stall freezes EX/MEM and blocks multiplier issue
        applyStimulus(1'b1, OP_ADD, 5'd14, 5'd15, 5'd21, 32'h200, 32'h55, 32'd4, 1'b1, 1'b1, 2'b10);
        tick();
        checkExMem("load_addr", 1'b1, 1'b1, 2'b10, 5'd21, 32'h204);
        checkOutput("load_wdata", 64'(ex_wdata), 64'h55);
        mem_stall = 1'b1;
        applyStimulus(1'b1, OP_MUL, 5'd14, 5'd15, 5'd22, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        checkOutput("stall_no_issue", 64'(ex_busy), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkExMem("stall_hold", 1'b1, 1'b1, 2'b10, 5'd21, 32'h204);
            checkOutput("stall_hold_wdata", 64'(ex_wdata), 64'h55);
        end
        checkOutput("stall_state_idle", 64'(dut.state), 64'(ST_IDLE));
        applyStimulus(1'b1, OP_ADD, 5'd14, 5'd15, 5'd22, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 2'b00);
        mem_stall = 1'b0;
        tick();
        checkExMem("stall_release", 1'b1, 1'b1, 2'b00, 5'd22, 32'd2);
        bubble();
        tick();

        // Multiplier
        doMul("mul_lo",      OP_MUL,   32'h10000, 32'h10000, 5'd9, 0, 32'd0);
        doMul("mulhu",       OP_MULHU, 32'h10000, 32'h10000, 5'd24, 0, 32'd1);
        doMul("mul_mixed",   OP_MUL,   32'h12345678, 32'd9, 5'd26, 0, 32'hA3D70A38);
        doMul("mulhu_stall", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, 3, 32'hFFFFFFFE);

        // Flush at T+10 aborts the multiply
        applyStimulus(1'b1, OP_MUL, 5'd16, 5'd17, 5'd9, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        bubble();
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", 64'(ex_valid), 64'd0);
        @(negedge clk);
        checkOutput("flush_busy", 64'(ex_busy), 64'd0);
        checkOutput("flush_state", 64'(dut.state), 64'(ST_IDLE));
        late_valid = 0;
        for (int i = 0; i < XLEN + 4; i++) begin
            tick();
            if (ex_valid) late_valid++;
        end
        checkOutput("flush_no_late_result", 64'(late_valid), 64'd0);
        applyStimulus(1'b1, OP_ADD, 5'd28, 5'd29, 5'd27, 32'd2, 32'd2, 32'd0, 1'b0, 1'b1, 2'b00);
        tick();
        checkExMem("post_flush_add", 1'b1, 1'b1, 2'b00, 5'd27, 32'd4);
        flush     = 1'b1;
        mem_stall = 1'b1;
        applyStimulus(1'b1, OP_ADD, 5'd28, 5'd29, 5'd27, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 2'b00);
        tick();
        flush     = 1'b0;
        mem_stall = 1'b0;
        checkOutput("flush_over_stall", 64'({ex_valid, ex_wb, ex_mem}), 64'd0);

        // Reset in the middle of a multiply
        applyStimulus(1'b1, OP_MUL, 5'd30, 5'd31, 5'd9, 32'd7, 32'd8, 32'd0, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        bubble();
        tick();
        checkExMem("rst_mid_run", 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
        checkOutput("rst_mid_run_wdata", 64'(ex_wdata), 64'd0);
        @(negedge clk);
        checkOutput("rst_mid_run_busy", 64'(ex_busy), 64'd0);
        checkOutput("rst_mid_run_state", 64'(dut.state), 64'(ST_IDLE));
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_stage_md.md
Name: exec_stage_md

Overview:
Parametrised execute stage for the in-order RISC-V pipeline, sitting between ID/EX and EX/MEM. It owns the EX/MEM pipeline register. Over the current EX stage it adds:
- configurable XLEN
- correct two-level forwarding priority
- SLT/SLTU ops
- an iterative multiplier (MUL/MULHU) with a busy handshake that stalls upstream
- a synchronous flush input

Parameters:
XLEN, 32, datapath width (≥8, power of two)
MUL_EN, 1, 1 = multiplier present; 0 = MUL/MULHU decode as illegal (result 0, no busy)
SHW, $clog2(XLEN), derived shift-amount width (localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
mem_stall  in  1  downstream stall; hold EX/MEM register
flush  in  1  squash EX contents; inject bubble
id_valid  in  1  ID/EX holds a real instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_data1, id_data2, id_imm  in  XLEN each  register-file operands, immediate
id_wb  in  1  instruction writes rd
id_mem  in  2  {MemRead, MemWrite}
id_aluop  in  4  op code (see package)
id_alusrc  in  1  1 = operand B is id_imm
wb_data  in  XLEN  writeback-stage data
wb_we, wb_rd  in  1, 5  writeback-stage write enable, destination
ex_busy  out  1  multiplier occupied; ID/EX must hold
ex_valid, ex_wb  out  1 each  registered valid, writeback enable
ex_mem  out  2  registered mem control
ex_result  out  XLEN  registered ALU/MUL result
ex_wdata  out  XLEN  registered store data (forwarded rs2)
ex_rd  out  5  registered destination

Behaviour:
- Reset: all outputs 0, FSM IDLE, multiplier counter 0.
- Forwarding, per source rs ∈ {rs1, rs2}:
  - EX hit = ex_valid & ex_wb & ex_rd≠0 & ex_rd==rs → use ex_result.
  - Else WB hit = wb_we & wb_rd≠0 & wb_rd==rs → use wb_data.
  - Else use the register-file value.
  - EX hit has priority over WB hit.
- Operands: A = fwd rs1. B = id_alusrc ? id_imm : fwd rs2. ex_wdata always gets fwd rs2, never the immediate.
- Ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift by B[SHW-1:0] only.
  - 8 SLT (signed), 9 SLTU: result 1 or 0, zero-extended.
  - 10 MUL: low XLEN of unsigned product. 11 MULHU: high XLEN of unsigned product.
  - 12–15: result 0.
- Single-cycle ops: result registered at the next edge when !mem_stall. Latency 1.
- Multiplier FSM: IDLE → RUN → DONE → IDLE.
  - IDLE: if id_valid & MUL/MULHU & !flush, latch A, B and the op into the multiplier, set cnt=0, go to RUN. ex_busy=1 combinationally in this issue cycle T.
  - RUN: one shift-add bit per cycle, cnt++. Runs for XLEN cycles (T+1..T+XLEN), then DONE. RUN continues regardless of mem_stall. ex_busy=1.
  - DONE: ex_busy=0. If !mem_stall, load EX/MEM with the product and go to IDLE; otherwise hold in DONE.
  - Result is visible at T+XLEN+2 when there is no stall.
- While busy and not in DONE, each !mem_stall edge loads a bubble (valid, wb, mem = 0) into EX/MEM.
- mem_stall: EX/MEM register holds all fields. No new MUL issues.
- flush: takes priority over mem_stall and the FSM. At the edge, EX/MEM gets a bubble, the FSM goes to IDLE, and any multiply in flight is aborted. rst takes priority over flush.
- id_valid=0: a bubble is registered.
- Arithmetic is modulo 2^XLEN. SUB uses two's complement.

Decomposition:
- Package exec_pkg: 4-bit op-code localparams, FSM state encoding (IDLE, RUN, DONE), forward-select encoding (RF, EX, WB).
- Sub-module seq_multiplier (XLEN-parametrised). Inputs: start, abort, a, b. Outputs: done, 2·XLEN product. Radix-2 shift-add with an internal counter.

Test Plan:
1. ADD forwarding priority: ADD x1=5+7, then ADD x2=x1+x1 while WB writes x1=99. Required: ex_result=12 then 24; EX data beats the older WB data.
2. Store data: SW with alusrc=1, imm=8, rs2=x3 forwarded from WB with 0xDEADBEEF. Required: ex_result=base+8, ex_wdata=0xDEADBEEF.
3. Shifts and compares: SRA 0x80000000 by B=33 → 0xC0000000 (amount 1). SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
4. MUL/MULHU: MUL 0x10000×0x10000 issued at T. Required: ex_busy high T..T+32, ex_result=0 at T+34. MULHU on the same operands → 1.
5. mem_stall: assert mem_stall for 3 cycles at DONE. Required: DONE is held, ex_busy=0, the result appears 1 cycle after stall release, and all EX/MEM fields are frozen during the stall.
6. flush and reset: flush at T+10 of a MUL → next cycle ex_busy=0, ex_valid=0, FSM IDLE. rst mid-RUN → all outputs 0.
